universal_register: RTL and testbench

- Parametrised successor to the team's single-bit reset D flip-flop.
- A WIDTH-bit register with clock enable and eight synchronous operating modes: hold, parallel load, shift, rotate, increment and clear.
- Registered carry/shift-out flag for chaining instances.
- Used as the general-purpose storage/shift element in datapath labs: accumulators, serial converters, counters.

---
 rtl/ureg_pkg.sv | 23 ++
 rtl/ureg_next.sv | 90 +++++++++
 rtl/universal_register.sv | 59 +++++
 tb/tb_universal_register.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ureg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ureg_pkg
//  Brief    : Shared mode encodings and width limit for universal_register
//  Revision : 1.0 - initial release
// ============================================================================
package ureg_pkg;

    // Operation select encodings
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Largest supported register width
    localparam int WIDTH_MAX = 32;

endpackage : ureg_pkg
`default_nettype wire

// File: rtl/ureg_next.sv
`default_nettype none
// ============================================================================
//  Module   : ureg_next
//  Brief    : Combinational next-state (Q and CO) for universal_register
//  Revision : 1.0 - initial release
// ============================================================================
module ureg_next
    import ureg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] next_q,
    output logic             next_co
);

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH:0]   w_inc;

    // A single-bit register has no interior bits to slice, so shifts collapse
    // to loading SI and rotates collapse to keeping Q.
    generate
        if (WIDTH > 1) begin : g_wide
            assign w_shl = {q[WIDTH-2:0], si};
            assign w_shr = {si, q[WIDTH-1:1]};
            assign w_rol = {q[WIDTH-2:0], q[WIDTH-1]};
            assign w_ror = {q[0], q[WIDTH-1:1]};
        end else begin : g_narrow
            assign w_shl = si;
            assign w_shr = si;
            assign w_rol = q;
            assign w_ror = q;
        end
    endgenerate

    // Extra top bit of the sum is the wrap-around carry
    assign w_inc = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};

    // Select next register value and carry/shift-out bit by mode
    always_comb begin
        next_q  = q;
        next_co = 1'b0;
        case (mode)
            MODE_HOLD: begin
                next_q  = q;
                next_co = 1'b0;
            end
            MODE_LOAD: begin
                next_q  = d;
                next_co = 1'b0;
            end
            MODE_SHL: begin
                next_q  = w_shl;
                next_co = q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q  = w_shr;
                next_co = q[0];
            end
            MODE_ROL: begin
                next_q  = w_rol;
                next_co = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q  = w_ror;
                next_co = q[0];
            end
            MODE_INC: begin
                next_q  = w_inc[WIDTH-1:0];
                next_co = w_inc[WIDTH];
            end
            MODE_CLR: begin
                next_q  = {WIDTH{1'b0}};
                next_co = 1'b0;
            end
            default: begin
                next_q  = q;
                next_co = 1'b0;
            end
        endcase
    end

endmodule : ureg_next
`default_nettype wire

// File: rtl/universal_register.sv
`default_nettype none
// ============================================================================
//  Module   : universal_register
//  Brief    : WIDTH-bit register with enable, load/shift/rotate/inc/clear
//             modes and a registered carry/shift-out flag for chaining
//  Revision : 1.0 - initial release
// ============================================================================
module universal_register
    import ureg_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             CO
);

    // Reset value truncated to the register width
    localparam logic [WIDTH-1:0] c_RESET_Q = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic [WIDTH-1:0] w_next_q;
    logic             w_next_co;

    ureg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .mode    (mode),
        .q       (r_q),
        .d       (D),
        .si      (SI),
        .next_q  (w_next_q),
        .next_co (w_next_co)
    );

    // HOLD must keep CO as well, so it is excluded from the update here
    // rather than relying on the next-state block for the old carry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q  <= c_RESET_Q;
            r_co <= 1'b0;
        end else if (en && (mode != MODE_HOLD)) begin
            r_q  <= w_next_q;
            r_co <= w_next_co;
        end
    end

    assign Q  = r_q;
    assign CO = r_co;

endmodule : universal_register
`default_nettype wire

// File: tb/tb_universal_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_universal_register
//  Brief    : Self-checking bench for universal_register (WIDTH=8 and WIDTH=1)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_universal_register;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d8;
    logic       d1;
    logic       si;
    logic [7:0] q8;
    logic       co8;
    logic       q1;
    logic       co1;

    int checks;
    int errors;

    universal_register #(.WIDTH(8), .RESET_VALUE(32'hA5)) dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .D(d8), .SI(si), .Q(q8), .CO(co8)
    );

    // RESET_VALUE truncates to 1'b1 on the single-bit instance
    universal_register #(.WIDTH(1), .RESET_VALUE(32'hA5)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .D(d1), .SI(si), .Q(q1), .CO(co1)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] d8;
        logic       d1;
        logic       si;
        logic [7:0] q8;
        logic       co8;
        logic       q1;
        logic       co1;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_q8, input logic e_co8,
                             input logic e_q1, input logic e_co1);
        check({tag, " q8"},  {24'd0, q8},  {24'd0, e_q8});
        check({tag, " co8"}, {31'd0, co8}, {31'd0, e_co8});
        check({tag, " q1"},  {31'd0, q1},  {31'd0, e_q1});
        check({tag, " co1"}, {31'd0, co1}, {31'd0, e_co1});
    endtask

    // Behavioural reference: each mode as plain integer arithmetic on a
    // w-bit value; en=0 and HOLD leave both Q and CO alone.
    function automatic void model(input int w, input int q, input int co, input int e,
                                  input int m, input int d, input int s,
                                  output int nq, output int nco);
        int mask;
        mask = (1 << w) - 1;
        nq   = q;
        nco  = co;
        if (e == 0) return;
        case (m)
            0: begin nq = q; nco = co; end
            1: begin nq = d & mask; nco = 0; end
            2: begin nq = ((q << 1) | s) & mask;             nco = (q >> (w - 1)) & 1; end
            3: begin nq = (q >> 1) | (s << (w - 1));          nco = q & 1; end
            4: begin nq = ((q << 1) | (q >> (w - 1))) & mask; nco = (q >> (w - 1)) & 1; end
            5: begin nq = (q >> 1) | ((q & 1) << (w - 1));    nco = q & 1; end
            6: begin nq = (q + 1) % (mask + 1);               nco = (q == mask) ? 1 : 0; end
            default: begin nq = 0; nco = 0; end
        endcase
    endfunction

    initial begin
        int mq8, mco8, mq1, mco1;
        int nq, nco;
        int r_en, r_mode, r_d8, r_d1, r_si;

        checks = 0;
        errors = 0;

        //            en    mode    d8     d1    si    q8     co8   q1    co1
        tbl[0]  = '{1'b1, 3'd1, 8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0}; // LOAD
        tbl[1]  = '{1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0}; // en=0 CLR
        tbl[2]  = '{1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0}; // en=0 CLR
        tbl[3]  = '{1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1}; // SHL si=0
        tbl[4]  = '{1'b1, 3'd3, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0}; // SHR si=1
        tbl[5]  = '{1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1}; // ROL
        tbl[6]  = '{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 1'b1, 1'b1}; // ROR
        tbl[7]  = '{1'b1, 3'd1, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0}; // LOAD
        tbl[8]  = '{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0}; // INC
        tbl[9]  = '{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1}; // INC wrap
        tbl[10] = '{1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}; // CLR
        tbl[11] = '{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0}; // INC
        tbl[12] = '{1'b1, 3'd0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0}; // HOLD

        // Asynchronous reset mid-cycle, no clock edge needed
        reset = 1'b1;
        en    = 1'b0;
        mode  = 3'd0;
        d8    = 8'h00;
        d1    = 1'b0;
        si    = 1'b0;
        #5 reset = 1'b0;
        #1 check_all("async reset", 8'hA5, 1'b0, 1'b1, 1'b0);

        // Reset held low across two edges while a LOAD is requested
        en   = 1'b1;
        mode = 3'd1;
        d8   = 8'h3C;
        d1   = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_all("reset held", 8'hA5, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            en   = tbl[i].en;
            mode = tbl[i].mode;
            d8   = tbl[i].d8;
            d1   = tbl[i].d1;
            si   = tbl[i].si;
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", i), tbl[i].q8, tbl[i].co8, tbl[i].q1, tbl[i].co1);
        end

        // Reset pulsed between edges during an INC sequence
        en   = 1'b1;
        mode = 3'd6;
        #4 reset = 1'b0;
        #5 check_all("mid reset", 8'hA5, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 check_all("inc after reset", 8'hA6, 1'b0, 1'b0, 1'b1);

        // Randomised phase against the reference model
        mq8 = 'hA6; mco8 = 0; mq1 = 0; mco1 = 1;
        for (int n = 0; n < 400; n++) begin
            r_en   = ($urandom_range(0, 7) != 0) ? 1 : 0;
            r_mode = $urandom_range(0, 7);
            r_d8   = $urandom_range(0, 255);
            r_d1   = $urandom_range(0, 1);
            r_si   = $urandom_range(0, 1);
            en   = r_en[0];
            mode = r_mode[2:0];
            d8   = r_d8[7:0];
            d1   = r_d1[0];
            si   = r_si[0];
            if ($urandom_range(0, 39) == 0) begin
                #4 reset = 1'b0;
                #2 check_all("rand reset", 8'hA5, 1'b0, 1'b1, 1'b0);
                reset = 1'b1;
                mq8 = 'hA5; mco8 = 0; mq1 = 1; mco1 = 0;
            end
            model(8, mq8, mco8, r_en, r_mode, r_d8, r_si, nq, nco);
            mq8 = nq; mco8 = nco;
            model(1, mq1, mco1, r_en, r_mode, r_d1, r_si, nq, nco);
            mq1 = nq; mco1 = nco;
            @(posedge clk);
            #1 check_all($sformatf("rand%0d m%0d", n, r_mode),
                         mq8[7:0], mco8[0], mq1[0], mco1[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_universal_register
`default_nettype wire
